// File: rtl/spi_slave_if.sv
// spi_slave_if -- SPI bus bundle between an SPI master and spi_slave.
//   sck     : SPI clock from master
//   cs_n    : chip select, active-low
//   mosi    : master-out data
//   miso    : slave-out data
//   miso_oe : miso drive enable, high only while the slave is selected
// Modports: master (drives sck/cs_n/mosi), slave (drives miso/miso_oe).
interface spi_slave_if;
   logic sck;
   logic cs_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (
      output sck,
      output cs_n,
      output mosi,
      input  miso,
      input  miso_oe
   );

   modport slave (
      input  sck,
      input  cs_n,
      input  mosi,
      output miso,
      output miso_oe
   );
endinterface

// File: rtl/spi_slave.sv
// spi_slave -- oversampling SPI slave, all four modes, 1..MAX_DATA_WIDTH bit
// words, MSB first, back-to-back words while cs_n stays low.
//
// Ports:
//   clk, rst          system clock (rising edge), asynchronous active-high reset
//   spi               spi_slave_if.slave: sck, cs_n, mosi in; miso, miso_oe out
//   cpol, cpha        SPI mode, captured at frame start
//   bits_per_word     word length minus one, captured at frame start
//   data_in           transmit word, sampled at frame start and between words
//   data_out          last completely received word
//   busy              high while a frame is in progress
//   new_data          one-clk pulse when data_out has been updated
//   rd_ack, overrun   only with SPI_SLAVE_OVERRUN_DET_EN defined: rd_ack
//                     acknowledges data_out; overrun is sticky when a word
//                     arrives before the previous one was acknowledged
//
// Optional feature macro: SPI_SLAVE_OVERRUN_DET_EN
//
// sck high and low times must each be at least 3 clk periods.
module spi_slave #(
   parameter int unsigned MAX_DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   spi_slave_if.slave                spi,
   input  logic                      cpol,
   input  logic                      cpha,
   input  logic [4:0]                bits_per_word,
   input  logic [MAX_DATA_WIDTH-1:0] data_in,
   output logic [MAX_DATA_WIDTH-1:0] data_out,
   output logic                      busy,
   output logic                      new_data
`ifdef SPI_SLAVE_OVERRUN_DET_EN
   ,
   input  logic                      rd_ack,
   output logic                      overrun
`endif
);

   localparam logic [4:0] BPW_MAX = 5'(MAX_DATA_WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state_q, state_d;

   // synchronizers and edge history
   logic [1:0] sck_sync, cs_sync, mosi_sync;
   logic [1:0] sync_live;
   logic       sck_s, cs_s, mosi_s;
   logic       sck_d, cs_d;

   // per-frame copies of the configuration
   logic       cpol_r, cpha_r;
   logic [4:0] bpw_r;

   logic [4:0]                bit_cnt;
   logic [MAX_DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next;
   logic [MAX_DATA_WIDTH-1:0] start_word, reload_word, frame_mask;
   logic [4:0]                bpw_in;

   logic cs_fall, lead_edge, trail_edge, sample_edge, shift_edge, last_bit;
   logic frame_start;

   function automatic logic [4:0] cap_bpw(input logic [4:0] b);
      return (32'(b) > 32'(BPW_MAX)) ? BPW_MAX : b;
   endfunction

   function automatic logic [MAX_DATA_WIDTH-1:0] word_mask(input logic [4:0] b);
      logic [MAX_DATA_WIDTH-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
         if (i <= 32'(b)) m[i] = 1'b1;
      end
      return m;
   endfunction

   assign sck_s  = sck_sync[1];
   assign cs_s   = cs_sync[1];
   assign mosi_s = mosi_sync[1];

   always_comb begin
      bpw_in      = cap_bpw(bits_per_word);
      start_word  = data_in & word_mask(bpw_in);
      frame_mask  = word_mask(bpw_r);
      reload_word = data_in & frame_mask;
      rx_next     = (rx_sr << 1) | {{(MAX_DATA_WIDTH-1){1'b0}}, mosi_s};
      last_bit    = (bit_cnt == bpw_r);

      // cs_d only ever holds a post-reset sample, so a cs_n that is already
      // low when reset is released never looks like a falling edge.
      cs_fall     = cs_d & ~cs_s;

      lead_edge   = (state_q == SHIFT) && (sck_d == cpol_r) && (sck_s != cpol_r);
      trail_edge  = (state_q == SHIFT) && (sck_d != cpol_r) && (sck_s == cpol_r);
      sample_edge = cpha_r ? trail_edge : lead_edge;
      shift_edge  = cpha_r ? lead_edge  : trail_edge;
   end

   // FSM: next state
   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d     = SHIFT;
               frame_start = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // synchronizers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // sck history rests at the idle clock level of the current mode
         sck_sync  <= {2{cpol}};
         sck_d     <= cpol;
         cs_sync   <= 2'b11;
         cs_d      <= 1'b0;
         mosi_sync <= 2'b00;
         sync_live <= 2'b00;
      end else begin
         sck_sync  <= {sck_sync[0], spi.sck};
         sck_d     <= sck_s;
         cs_sync   <= {cs_sync[0], spi.cs_n};
         cs_d      <= sync_live[1] & cs_s;
         mosi_sync <= {mosi_sync[0], spi.mosi};
         sync_live <= {sync_live[0], 1'b1};
      end
   end

   // datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpol_r   <= 1'b0;
         cpha_r   <= 1'b0;
         bpw_r    <= '0;
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         data_out <= '0;
         new_data <= 1'b0;
      end else begin
         new_data <= 1'b0;
         if (frame_start) begin
            cpol_r  <= cpol;
            cpha_r  <= cpha;
            bpw_r   <= bpw_in;
            tx_sr   <= start_word;
            rx_sr   <= '0;
            bit_cnt <= '0;
         end else if (state_q == SHIFT && !cs_s) begin
            if (sample_edge) begin
               rx_sr <= rx_next;
               if (last_bit) begin
                  bit_cnt  <= '0;
                  data_out <= rx_next & frame_mask;
                  new_data <= 1'b1;
                  if (cpha_r) tx_sr <= reload_word;
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            if (shift_edge) begin
               // cpha=1: the first leading edge of a word presents the
               //         already-loaded MSB, so no shift at bit 0.
               // cpha=0: the trailing edge after the last bit of a word
               //         loads the next word instead of shifting.
               if (cpha_r) begin
                  if (bit_cnt != 5'd0) tx_sr <= tx_sr << 1;
               end else begin
                  if (bit_cnt == 5'd0) tx_sr <= reload_word;
                  else                 tx_sr <= tx_sr << 1;
               end
            end
         end
      end
   end

   always_comb begin
      busy        = (state_q == SHIFT);
      spi.miso_oe = (state_q == SHIFT);
      spi.miso    = (state_q == SHIFT) ? tx_sr[bpw_r] : 1'b0;
   end

`ifdef SPI_SLAVE_OVERRUN_DET_EN
   logic valid;

   // An acknowledge in the same cycle as new_data consumes the old word,
   // so the new word is valid but no overrun is flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (new_data) begin
            valid <= 1'b1;
            if (valid && !rd_ack) overrun <= 1'b1;
         end else if (rd_ack) begin
            valid <= 1'b0;
         end
         if (rd_ack) overrun <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- randomized and directed bench for spi_slave with a
// behavioural model: expected busy from cs_n history, expected data_out from
// a queue of words the master sent, expected master-received words from
// data_in.
module tb_spi_slave;

   localparam int H = 6;   // sck half period in clk cycles

   logic        clk = 1'b0;
   logic        rst;
   logic        cpol, cpha;
   logic [4:0]  bits_per_word;
   logic [31:0] data_in, data_out;
   logic        busy, new_data;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
   logic        rd_ack, overrun;
`endif

   spi_slave_if spi_bus();

   always #5 clk = ~clk;

   spi_slave #(.MAX_DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .spi           (spi_bus),
      .cpol          (cpol),
      .cpha          (cpha),
      .bits_per_word (bits_per_word),
      .data_in       (data_in),
      .data_out      (data_out),
      .busy          (busy),
      .new_data      (new_data)
`ifdef SPI_SLAVE_OVERRUN_DET_EN
      ,
      .rd_ack        (rd_ack),
      .overrun       (overrun)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural model ----------------
   logic [3:0]  hist = 4'hF;       // cs_n as seen at the last four clk edges
   int          since = 0;         // clk edges since reset release
   logic        busy_m = 1'b0;
   logic [31:0] exp_dout = '0;
   logic [31:0] exp_q[$];
   int          nd_count = 0;

   initial forever begin
      @(posedge clk);
      if (rst) since = 0;
      else begin
         hist = {hist[2:0], spi_bus.cs_n};
         if (since < 100) since++;
      end
   end

   // cs_n passes a 2-flop synchronizer and a state register: busy reflects
   // a falling edge seen two and three samples back; only post-reset
   // samples can form that edge.
   initial forever begin
      logic cs_s_m, cs_d_m;
      @(negedge clk);
      if (rst) begin
         busy_m   = 1'b0;
         exp_dout = '0;
         exp_q.delete();
      end else begin
         cs_s_m = (since > 2) ? hist[2] : 1'b1;
         cs_d_m = (since > 3) ? hist[3] : 1'b0;
         busy_m = busy_m ? !cs_s_m : (cs_d_m && !cs_s_m);
         if (new_data) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL new_data_unexpected: got 1 expected 0 (t=%0t)", $time);
            end else begin
               exp_dout = exp_q.pop_front();
               nd_count++;
            end
         end
      end
      chk1("busy", busy, busy_m);
      chk1("miso_oe", spi_bus.miso_oe, busy_m);
      if (!busy_m) chk1("miso_idle", spi_bus.miso, 1'b0);
      chk32("data_out", data_out, exp_dout);
   end

   // ---------------- master ----------------
   logic [31:0] m_tx[4], s_tx[4], m_rx[4];

   // nw words; abort_bits >= 0 ends the last word after that many bits, by
   // raising cs_n or, when rst_abort is set, by asserting rst.
   task automatic run_frame(input logic pol, input logic pha, input logic [4:0] bpw,
                            input int nw, input int abort_bits, input bit rst_abort);
      logic [31:0] mask;
      int          nd0, done_bits;
      bit          aborted;
      mask = '0;
      for (int i = 0; i <= int'(bpw); i++) mask[i] = 1'b1;
      cpol          = pol;
      cpha          = pha;
      bits_per_word = bpw;
      spi_bus.sck   = pol;
      spi_bus.mosi  = 1'b0;
      data_in       = s_tx[0];
      tick(6);
      nd0     = nd_count;
      aborted = 1'b0;
      spi_bus.cs_n = 1'b0;
      if (!pha) spi_bus.mosi = m_tx[0][bpw];
      tick(H);
      for (int w = 0; w < nw && !aborted; w++) begin
         m_rx[w]   = '0;
         done_bits = 0;
         for (int b = int'(bpw); b >= 0; b--) begin
            if (abort_bits >= 0 && w == nw - 1 && done_bits == abort_bits) begin
               aborted = 1'b1;
               break;
            end
            if (!pha) begin
               m_rx[w][b] = spi_bus.miso;
               if (b == 0) exp_q.push_back(m_tx[w] & mask);
               spi_bus.sck = ~pol;
               tick(H);
               if (b == int'(bpw) && w + 1 < nw) data_in = s_tx[w+1];
               spi_bus.sck = pol;
               if (b > 0)          spi_bus.mosi = m_tx[w][b-1];
               else if (w + 1 < nw) spi_bus.mosi = m_tx[w+1][bpw];
               tick(H);
            end else begin
               spi_bus.sck  = ~pol;
               spi_bus.mosi = m_tx[w][b];
               tick(H);
               if (b == int'(bpw) && w + 1 < nw) data_in = s_tx[w+1];
               m_rx[w][b] = spi_bus.miso;
               if (b == 0) exp_q.push_back(m_tx[w] & mask);
               spi_bus.sck = pol;
               tick(H);
            end
            done_bits++;
         end
         if (!aborted) chk32("master_rx", m_rx[w], s_tx[w] & mask);
      end
      if (aborted && rst_abort) begin
         rst = 1'b1;
         #1;
         chk1("rst_busy", busy, 1'b0);
         chk1("rst_miso", spi_bus.miso, 1'b0);
         chk1("rst_miso_oe", spi_bus.miso_oe, 1'b0);
         chk1("rst_new_data", new_data, 1'b0);
         chk32("rst_data_out", data_out, 32'h0);
         tick(3);
         rst = 1'b0;
         tick(10);
         chk1("no_frame_after_rst", busy, 1'b0);
         spi_bus.cs_n = 1'b1;
         tick(6);
      end else begin
         spi_bus.cs_n = 1'b1;
         tick(6);
         chk32("new_data_count", 32'(nd_count - nd0), 32'(aborted ? nw - 1 : nw));
         chk32("pending_words", 32'(exp_q.size()), 32'h0);
         chk1("end_busy", busy, 1'b0);
         chk1("end_miso_oe", spi_bus.miso_oe, 1'b0);
      end
   endtask

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL timeout: simulation did not finish within the cycle budget");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      cpol          = 1'b0;
      cpha          = 1'b0;
      bits_per_word = 5'd7;
      data_in       = '0;
      spi_bus.sck   = 1'b0;
      spi_bus.cs_n  = 1'b1;
      spi_bus.mosi  = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
      rd_ack        = 1'b0;
`endif
      tick(4);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_miso", spi_bus.miso, 1'b0);
      chk1("reset_miso_oe", spi_bus.miso_oe, 1'b0);
      chk1("reset_new_data", new_data, 1'b0);
      chk32("reset_data_out", data_out, 32'h0);
      rst = 1'b0;
      tick(4);

      // mode 0, 8 bits
      m_tx[0] = 32'h3C; s_tx[0] = 32'hA5;
      run_frame(1'b0, 1'b0, 5'd7, 1, -1, 1'b0);
      chk32("mode0_master_rx", m_rx[0], 32'h0000_00A5);
      chk32("mode0_data_out", data_out, 32'h0000_003C);

      // mode 3, 32 bits
      m_tx[0] = 32'h1234_5678; s_tx[0] = 32'hDEAD_BEEF;
      run_frame(1'b1, 1'b1, 5'd31, 1, -1, 1'b0);
      chk32("mode3_master_rx", m_rx[0], 32'hDEAD_BEEF);
      chk32("mode3_data_out", data_out, 32'h1234_5678);

`ifdef SPI_SLAVE_OVERRUN_DET_EN
      rd_ack = 1'b1; tick(1); rd_ack = 1'b0; tick(1);
      chk1("overrun_cleared", overrun, 1'b0);
`endif

      // back-to-back words, data_in re-sampled between them
      m_tx[0] = 32'h11; m_tx[1] = 32'h22;
      s_tx[0] = 32'h81; s_tx[1] = 32'h7E;
      run_frame(1'b0, 1'b0, 5'd7, 2, -1, 1'b0);
      chk32("b2b_second_rx", m_rx[1], 32'h0000_007E);
      chk32("b2b_data_out", data_out, 32'h0000_0022);

`ifdef SPI_SLAVE_OVERRUN_DET_EN
      chk1("overrun_set", overrun, 1'b1);
      rd_ack = 1'b1; tick(1); rd_ack = 1'b0; tick(1);
      chk1("overrun_ack", overrun, 1'b0);
`endif

      // abort after 5 of 8 bits
      m_tx[0] = 32'hFF; s_tx[0] = 32'h5A;
      run_frame(1'b0, 1'b1, 5'd7, 1, 5, 1'b0);
      chk32("abort_data_out", data_out, 32'h0000_0022);

      // reset mid-word, then a clean frame
      m_tx[0] = 32'hC3; s_tx[0] = 32'h99;
      run_frame(1'b1, 1'b0, 5'd7, 1, 3, 1'b1);
      m_tx[0] = 32'h5A; s_tx[0] = 32'h3C;
      run_frame(1'b0, 1'b0, 5'd7, 1, -1, 1'b0);
      chk32("after_rst_data_out", data_out, 32'h0000_005A);

      // randomized frames
      for (int n = 0; n < 10; n++) begin
         logic       pol, pha;
         logic [4:0] bpw;
         int         nw, ab;
         pol = 1'($urandom_range(0, 1));
         pha = 1'($urandom_range(0, 1));
         bpw = 5'($urandom_range(0, 31));
         nw  = int'($urandom_range(1, 3));
         for (int w = 0; w < 4; w++) begin
            m_tx[w] = $urandom;
            s_tx[w] = $urandom;
         end
         ab = -1;
         if (bpw != 5'd0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 32'(bpw)));
         run_frame(pol, pha, bpw, nw, ab, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
